// File: rtl/matmul_mem_master.sv
// Memory-side initiator for a DIMxDIM matrix multiply: reads A and B, writes C = A x B row-major.
// Define MATMUL_SATURATE_EN for a saturating accumulator and the o_sat_flag output.
module matmul_mem_master #(
  parameter int unsigned DIM    = 3,
  parameter logic [31:0] A_BASE = 32'h0000_0200,
  parameter logic [31:0] B_BASE = 32'h0000_0300,
  parameter logic [31:0] C_BASE = 32'h0000_0100,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_memread,
  output logic              o_memwrite,
  output logic [31:0]       o_address,
  output logic [DATA_W-1:0] o_write_data,
`ifdef MATMUL_SATURATE_EN
  output logic              o_sat_flag,
`endif
  input  logic [DATA_W-1:0] i_read_data
);

  localparam int unsigned IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWr, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [IW-1:0]     r_i, r_j, r_k, w_i_d, w_j_d, w_k_d;
  logic [DATA_W-1:0] r_a, w_a_d, r_acc, w_acc_d, w_acc_sum;
  logic [DATA_W-1:0] r_wdata, w_wdata_d;
  logic [31:0]       r_address, w_address_d;
  logic              r_memread, w_memread_d, r_memwrite, w_memwrite_d;
  logic              r_busy, r_done;
  logic              w_set_sat, w_clr_sat;

  function automatic logic [31:0] f_addr(input logic [31:0] base, input logic [IW-1:0] row,
                                         input logic [IW-1:0] col);
    logic [31:0] r32, c32;
    r32 = 32'(row);
    c32 = 32'(col);
    return base + ((r32 * DIM + c32) << 2);
  endfunction

`ifdef MATMUL_SATURATE_EN
  localparam int unsigned SW = 2 * DATA_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [2*DATA_W-1:0]   w_prod;
  logic signed [SW-1:0]  w_sum_wide;
  logic                  w_sat;
  logic                  r_sat;

  // Full-width signed product plus sign-extended accumulator, clamped to DATA_W.
  assign w_prod = $signed({{DATA_W{r_a[DATA_W-1]}}, r_a}) *
                  $signed({{DATA_W{i_read_data[DATA_W-1]}}, i_read_data});
  assign w_sum_wide = $signed({w_prod[2*DATA_W-1], w_prod}) +
                      $signed({{(DATA_W + 1){r_acc[DATA_W-1]}}, r_acc});

  always_comb begin
    w_sat     = 1'b0;
    w_acc_sum = w_sum_wide[DATA_W-1:0];
    if (w_sum_wide > SAT_MAX) begin
      w_sat     = 1'b1;
      w_acc_sum = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (w_sum_wide < SAT_MIN) begin
      w_sat     = 1'b1;
      w_acc_sum = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)        r_sat <= 1'b0;
    else if (w_clr_sat) r_sat <= 1'b0;
    else if (w_set_sat) r_sat <= 1'b1;
  end

  assign o_sat_flag = r_sat;
`else
  // Low DATA_W bits of the product are identical for signed and unsigned operands.
  logic [DATA_W-1:0] w_prod_lo;
  assign w_prod_lo = r_a * i_read_data;
  assign w_acc_sum = r_acc + w_prod_lo;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_i_d        = r_i;
    w_j_d        = r_j;
    w_k_d        = r_k;
    w_a_d        = r_a;
    w_acc_d      = r_acc;
    w_memread_d  = 1'b0;
    w_memwrite_d = 1'b0;
    w_address_d  = r_address;
    w_wdata_d    = r_wdata;
    w_set_sat    = 1'b0;
    w_clr_sat    = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d   = StRdA;
          w_i_d       = '0;
          w_j_d       = '0;
          w_k_d       = '0;
          w_acc_d     = '0;
          w_clr_sat   = 1'b1;
          w_memread_d = 1'b1;
          w_address_d = f_addr(A_BASE, '0, '0);
        end
      end
      StRdA: begin
        w_a_d       = i_read_data;
        w_state_d   = StRdB;
        w_memread_d = 1'b1;
        w_address_d = f_addr(B_BASE, r_k, r_j);
      end
      StRdB: begin
`ifdef MATMUL_SATURATE_EN
        w_set_sat = w_sat;
`endif
        w_acc_d = w_acc_sum;
        if (r_k == LAST) begin
          w_k_d        = '0;
          w_state_d    = StWr;
          w_memwrite_d = 1'b1;
          w_address_d  = f_addr(C_BASE, r_i, r_j);
          w_wdata_d    = w_acc_sum;
        end else begin
          w_k_d       = r_k + 1'b1;
          w_state_d   = StRdA;
          w_memread_d = 1'b1;
          w_address_d = f_addr(A_BASE, r_i, w_k_d);
        end
      end
      StWr: begin
        w_acc_d = '0;
        if (r_i == LAST && r_j == LAST) begin
          w_state_d = StDone;
        end else begin
          if (r_j == LAST) begin
            w_j_d = '0;
            w_i_d = r_i + 1'b1;
          end else begin
            w_j_d = r_j + 1'b1;
          end
          w_state_d   = StRdA;
          w_memread_d = 1'b1;
          w_address_d = f_addr(A_BASE, w_i_d, '0);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_a        <= '0;
      r_acc      <= '0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_i        <= w_i_d;
      r_j        <= w_j_d;
      r_k        <= w_k_d;
      r_a        <= w_a_d;
      r_acc      <= w_acc_d;
      r_memread  <= w_memread_d;
      r_memwrite <= w_memwrite_d;
      r_address  <= w_address_d;
      r_wdata    <= w_wdata_d;
      r_busy     <= (w_state_d != StIdle);
      r_done     <= (w_state_d == StDone);
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_memread    = r_memread;
  assign o_memwrite   = r_memwrite;
  assign o_address    = r_address;
  assign o_write_data = r_wdata;

endmodule

// File: tb/tb_matmul_mem_master.sv
// Bench for matmul_mem_master: memory model, timeline-based reference model and per-cycle compare.
module tb_matmul_mem_master;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, memread, memwrite;
  logic [31:0] address, write_data, read_data;
`ifdef MATMUL_SATURATE_EN
  logic        sat_flag;
`endif

  matmul_mem_master dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_memread    (memread),
    .o_memwrite   (memwrite),
    .o_address    (address),
    .o_write_data (write_data),
`ifdef MATMUL_SATURATE_EN
    .o_sat_flag   (sat_flag),
`endif
    .i_read_data  (read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] a_mem [9];
  logic [31:0] b_mem [9];
  logic [31:0] exp_c [9];
  logic [31:0] c_got [9];
  logic [31:0] rd_log [6];
  int n_asrt = 0, n_fail = 0;
  int m_cyc = 0, sat_cyc = 1000;
  bit m_sat_hold = 1'b0;
  int wr_count = 0, done_count = 0, rd_count = 0;

  // Combinational memory; garbage when not reading.
  always_comb begin
    read_data = 32'hDEAD_BEEF;
    if (memread && address[31:8] == 24'h2 && address[7:2] < 6'd9) read_data = a_mem[address[5:2]];
    if (memread && address[31:8] == 24'h3 && address[7:2] < 6'd9) read_data = b_mem[address[5:2]];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference C from plain matrix arithmetic; also the first cycle a clamp becomes visible.
  function automatic void compute_exp();
    longint acc, p;
    logic [31:0] acc32;
    logic [63:0] pv;
    logic [63:0] av;
    sat_cyc = 1000;
    for (int e = 0; e < 9; e++) begin
      acc = 0;
      acc32 = '0;
      for (int k = 0; k < 3; k++) begin
        p = longint'($signed(a_mem[(e / 3) * 3 + k])) * longint'($signed(b_mem[k * 3 + e % 3]));
        pv = p;
        acc32 = acc32 + pv[31:0];
        acc = acc + p;
        if (acc > 64'sd2147483647 || acc < -64'sd2147483648) begin
          acc = (acc > 0) ? 64'sd2147483647 : -64'sd2147483648;
          if (sat_cyc == 1000) sat_cyc = e * 7 + 2 * k + 3;
        end
      end
      av = acc;
`ifdef MATMUL_SATURATE_EN
      exp_c[e] = av[31:0];
`else
      exp_c[e] = acc32;
`endif
    end
  endfunction

  // Model timeline: m_cyc = 0 idle, 1..63 memory cycles, 64 done.
  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0;
      m_sat_hold = 1'b0;
      sat_cyc = 1000;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_cyc = 1;
        compute_exp();
        m_sat_hold = 1'b0;
      end
    end else if (m_cyc == 64) begin
      m_cyc = 0;
      m_sat_hold = (sat_cyc <= 64);
    end else begin
      m_cyc++;
    end
  end

  logic        x_rd, x_wr, x_sat;
  logic [31:0] x_addr;
  int          x_e, x_st, x_k;

  always @(negedge clk) begin
    x_rd = 1'b0;
    x_wr = 1'b0;
    x_addr = '0;
    x_e = 0;
    if (m_cyc >= 1 && m_cyc <= 63) begin
      x_e  = (m_cyc - 1) / 7;
      x_st = (m_cyc - 1) % 7;
      x_k  = x_st / 2;
      if (x_st == 6) begin
        x_wr = 1'b1;
        x_addr = 32'h100 + 32'(4 * x_e);
      end else if (x_st % 2 == 0) begin
        x_rd = 1'b1;
        x_addr = 32'h200 + 32'(4 * ((x_e / 3) * 3 + x_k));
      end else begin
        x_rd = 1'b1;
        x_addr = 32'h300 + 32'(4 * (x_k * 3 + x_e % 3));
      end
    end
    check("ctl{busy,done,rd,wr}", {busy, done, memread, memwrite},
          {m_cyc != 0, m_cyc == 64, x_rd, x_wr});
    if (x_rd || x_wr) check("address", address, x_addr);
    if (x_wr) check("write_data", write_data, exp_c[x_e]);
`ifdef MATMUL_SATURATE_EN
    x_sat = (m_cyc != 0) ? (m_cyc >= sat_cyc) : m_sat_hold;
    check("sat_flag", sat_flag, x_sat);
`endif
    if (memwrite && address[31:8] == 24'h1 && address[7:2] < 6'd9) begin
      c_got[address[5:2]] = write_data;
      wr_count++;
    end
    if (memread && rd_count < 6) begin
      rd_log[rd_count] = address;
      rd_count++;
    end
    if (done) done_count++;
  end

  // Pulses start, optional second start at cycle restart_at, optional reset at cycle reset_at.
  task automatic run_op(input int restart_at, input int reset_at, output int lat);
    int n;
    bit seen;
    for (int e = 0; e < 9; e++) c_got[e] = 32'h5A5A_5A5A;
    wr_count = 0;
    done_count = 0;
    rd_count = 0;
    n = 0;
    seen = 1'b0;
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
      if (reset_at != 0 && n == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lat = n;
        return;
      end
      if (done) seen = 1'b1;
    end
    lat = n;
    check("done_seen", seen, 1'b1);
    @(negedge clk);
  endtask

  int lat;
  logic [31:0] rd_exp [6];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int e = 0; e < 9; e++) begin
      a_mem[e] = '0;
      b_mem[e] = '0;
      exp_c[e] = '0;
      c_got[e] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, done, memread, memwrite}, 4'b0000);
    check("reset_address", address, 32'h0);
    check("reset_write_data", write_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // All-constant matrices
    for (int e = 0; e < 9; e++) begin
      a_mem[e] = 32'd1024;
      b_mem[e] = 32'd256;
    end
    run_op(0, 0, lat);
    check("t1_done_latency", lat, 64);
    check("t1_write_count", wr_count, 9);
    for (int e = 0; e < 9; e++) check("t1_c", c_got[e], 32'h000C_0000);

    // Identity times 1..9
    for (int e = 0; e < 9; e++) begin
      a_mem[e] = (e % 4 == 0) ? 32'd1 : 32'd0;
      b_mem[e] = 32'(e + 1);
    end
    run_op(0, 0, lat);
    for (int e = 0; e < 9; e++) check("t2_c", c_got[e], 32'(e + 1));
    rd_exp = '{32'h200, 32'h300, 32'h204, 32'h30C, 32'h208, 32'h318};
    for (int r = 0; r < 6; r++) check("t2_read_addr", rd_log[r], rd_exp[r]);

    // Start while busy is ignored
    run_op(10, 0, lat);
    check("t3_done_latency", lat, 64);
    check("t3_write_count", wr_count, 9);
    check("t3_done_count", done_count, 1);

    // Reset during the 4th write, then a fresh full run
    run_op(0, 28, lat);
    check("t4_after_reset", {busy, memread, memwrite}, 3'b000);
    check("t4_partial_writes", wr_count, 4);
    run_op(0, 0, lat);
    check("t4_rerun_write_count", wr_count, 9);
    check("t4_rerun_latency", lat, 64);
    for (int e = 0; e < 9; e++) check("t4_c", c_got[e], 32'(e + 1));

    // Overflow on the first product
    for (int e = 0; e < 9; e++) begin
      a_mem[e] = '0;
      b_mem[e] = '0;
    end
    a_mem[0] = 32'h4000_0000;
    b_mem[0] = 32'd4;
    run_op(0, 0, lat);
`ifdef MATMUL_SATURATE_EN
    check("t5_c00_saturated", c_got[0], 32'h7FFF_FFFF);
    check("t5_sat_flag", sat_flag, 1'b1);
`else
    check("t5_c00_wrapped", c_got[0], 32'h0000_0000);
`endif
    for (int e = 1; e < 9; e++) check("t5_c_rest", c_got[e], 32'h0);

    // Negative operands, no clamp
    for (int e = 0; e < 9; e++) begin
      a_mem[e] = 32'hFFFF_FFFF;
      b_mem[e] = 32'd2;
    end
    run_op(0, 0, lat);
    for (int e = 0; e < 9; e++) check("t6_c", c_got[e], 32'hFFFF_FFFA);
`ifdef MATMUL_SATURATE_EN
    check("t6_sat_flag", sat_flag, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
